// File: rtl/interrupt_dispatch_sequencer_if.sv
// Bundle between the interrupt dispatch sequencer, the interrupt controller and the CPU core.
// slave = sequencer side, master = controller/core side.
interface interrupt_dispatch_sequencer_if #(
    parameter int NUM_IRQ = 5
);
    logic               i_Enable;
    logic [NUM_IRQ-1:0] i_Interrupts;
    logic               i_Instr_Boundary;
    logic               i_Halt;
    logic               i_EI;
    logic               i_DI;
    logic               i_RETI;
    logic [15:0]        i_PC;
    logic [15:0]        i_SP;

    logic               o_IME;
    logic               o_Dispatch_Active;
    logic               o_Wake;
    logic               o_Mem_Wr;
    logic [15:0]        o_Mem_Addr;
    logic [7:0]         o_Mem_Data;
    logic               o_Load_PC;
    logic [15:0]        o_PC_Out;
    logic               o_Load_SP;
    logic [15:0]        o_SP_Out;
    logic               o_Interrupt_Handled;

    modport slave (
        input  i_Enable, i_Interrupts, i_Instr_Boundary, i_Halt,
        input  i_EI, i_DI, i_RETI, i_PC, i_SP,
        output o_IME, o_Dispatch_Active, o_Wake, o_Mem_Wr, o_Mem_Addr, o_Mem_Data,
        output o_Load_PC, o_PC_Out, o_Load_SP, o_SP_Out, o_Interrupt_Handled
    );

    modport master (
        output i_Enable, i_Interrupts, i_Instr_Boundary, i_Halt,
        output i_EI, i_DI, i_RETI, i_PC, i_SP,
        input  o_IME, o_Dispatch_Active, o_Wake, o_Mem_Wr, o_Mem_Addr, o_Mem_Data,
        input  o_Load_PC, o_PC_Out, o_Load_SP, o_SP_Out, o_Interrupt_Handled
    );
endinterface

// File: rtl/interrupt_dispatch_sequencer.sv
// Interrupt dispatch sequencer: owns IME / EI delay / HALT wake and runs the 5 M-cycle dispatch.
// Optional DISPATCH_CANCEL_EN: re-sample the vector after the high-byte push (DMG cancel quirk).
module interrupt_dispatch_sequencer #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic i_Clk,
    input  logic i_Rst,
    interrupt_dispatch_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT1,
        WAIT2,
        PUSH_HI,
        PUSH_LO,
        JUMP
    } state_t;

    state_t           state_reg;
    logic             ime_reg;
    logic             ei_pending_reg;
    logic [15:0]      sp_reg;
    logic [15:0]      pc_reg;
    logic [IDX_W-1:0] vec_reg;
`ifdef DISPATCH_CANCEL_EN
    logic             cancel_reg;
`endif

    logic             any_pending;
    logic             take;
    logic             live;
    logic [IDX_W-1:0] lowest_idx;
    logic [15:0]      vec_addr;
    logic [15:0]      jump_pc;
    logic             handled_ok;

    // Bit 0 has highest priority, so the lowest set bit wins.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        lowest_set = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    assign any_pending = |bus.i_Interrupts;
    assign take        = ime_reg & any_pending & (bus.i_Instr_Boundary | bus.i_Halt);
    assign lowest_idx  = lowest_set(bus.i_Interrupts);
    assign vec_addr    = VEC_BASE + 16'(VEC_STRIDE) * 16'(vec_reg);
    assign live        = bus.i_Enable & ~i_Rst;

`ifdef DISPATCH_CANCEL_EN
    assign jump_pc    = cancel_reg ? 16'h0000 : vec_addr;
    assign handled_ok = ~cancel_reg;
`else
    assign jump_pc    = vec_addr;
    assign handled_ok = 1'b1;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg      <= IDLE;
            ime_reg        <= 1'b0;
            ei_pending_reg <= 1'b0;
            sp_reg         <= '0;
            pc_reg         <= '0;
            vec_reg        <= '0;
`ifdef DISPATCH_CANCEL_EN
            cancel_reg     <= 1'b0;
`endif
        end else if (bus.i_Enable) begin
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        state_reg      <= WAIT1;
                        sp_reg         <= bus.i_SP;
                        pc_reg         <= bus.i_PC;
                        vec_reg        <= lowest_idx;
                        ime_reg        <= 1'b0;
                        ei_pending_reg <= 1'b0;
`ifdef DISPATCH_CANCEL_EN
                        cancel_reg     <= 1'b0;
`endif
                    end else begin
                        // EI takes effect at the boundary after the one following EI;
                        // later assignments win, so DI overrides RETI and EI.
                        if (ei_pending_reg && bus.i_Instr_Boundary) begin
                            ime_reg        <= 1'b1;
                            ei_pending_reg <= 1'b0;
                        end
                        if (bus.i_EI) begin
                            ei_pending_reg <= 1'b1;
                        end
                        if (bus.i_RETI) begin
                            ime_reg        <= 1'b1;
                            ei_pending_reg <= 1'b0;
                        end
                        if (bus.i_DI) begin
                            ime_reg        <= 1'b0;
                            ei_pending_reg <= 1'b0;
                        end
                    end
                end
                WAIT1:   state_reg <= WAIT2;
                WAIT2:   state_reg <= PUSH_HI;
                PUSH_HI: begin
                    state_reg <= PUSH_LO;
`ifdef DISPATCH_CANCEL_EN
                    if (any_pending) begin
                        vec_reg <= lowest_idx;
                    end else begin
                        cancel_reg <= 1'b1;
                    end
`endif
                end
                PUSH_LO: state_reg <= JUMP;
                JUMP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if ((state_reg != IDLE) && bus.i_DI) begin
                ime_reg        <= 1'b0;
                ei_pending_reg <= 1'b0;
            end
        end
    end

    // Bus requests are qualified by the M-cycle strobe so the arbiter sees exactly one beat.
    always_comb begin
        bus.o_Mem_Wr            = 1'b0;
        bus.o_Mem_Addr          = 16'h0000;
        bus.o_Mem_Data          = 8'h00;
        bus.o_Load_PC           = 1'b0;
        bus.o_PC_Out            = 16'h0000;
        bus.o_Load_SP           = 1'b0;
        bus.o_SP_Out            = 16'h0000;
        bus.o_Interrupt_Handled = 1'b0;
        if (live) begin
            case (state_reg)
                PUSH_HI: begin
                    bus.o_Mem_Wr   = 1'b1;
                    bus.o_Mem_Addr = sp_reg - 16'd1;
                    bus.o_Mem_Data = pc_reg[15:8];
                end
                PUSH_LO: begin
                    bus.o_Mem_Wr   = 1'b1;
                    bus.o_Mem_Addr = sp_reg - 16'd2;
                    bus.o_Mem_Data = pc_reg[7:0];
                end
                JUMP: begin
                    bus.o_Load_PC           = 1'b1;
                    bus.o_PC_Out            = jump_pc;
                    bus.o_Load_SP           = 1'b1;
                    bus.o_SP_Out            = sp_reg - 16'd2;
                    bus.o_Interrupt_Handled = handled_ok;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_IME             = ime_reg;
    assign bus.o_Dispatch_Active = (state_reg != IDLE);
    assign bus.o_Wake            = live & bus.i_Halt & any_pending;

endmodule

// File: tb/tb_interrupt_dispatch_sequencer.sv
// Scoreboard bench: a transaction-level model predicts stack writes, jumps, wake and IME per M-cycle.
module tb_interrupt_dispatch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interrupt_dispatch_sequencer_if #(.NUM_IRQ(5)) bus ();

    interrupt_dispatch_sequencer #(
        .NUM_IRQ   (5),
        .VEC_BASE  (16'h0040),
        .VEC_STRIDE(8)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // staged stimulus, applied at the next falling edge
    logic        s_rst = 1'b1, s_en = 1'b0, s_bnd = 1'b0, s_halt = 1'b0;
    logic        s_ei = 1'b0, s_di = 1'b0, s_reti = 1'b0;
    logic [4:0]  s_irq = 5'd0;
    logic [15:0] s_pc = 16'h0100, s_sp = 16'hFFFE;

    // reference model state
    logic        m_ime = 1'b0, m_eip = 1'b0, m_busy = 1'b0, m_cancel = 1'b0;
    int          m_cnt = 0, m_vec = 0;
    logic [15:0] m_pc = 16'h0, m_sp = 16'h0;

    logic [23:0] wr_q[$];
    logic [32:0] jmp_q[$];
    logic        ime_q[$];
    logic        act_q[$];
    logic        wake_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One M-cycle of the architectural behaviour: entry, 5-cycle dispatch, IME rules.
    function automatic void model_step();
        logic [15:0] a1, a2, vaddr;
        if (s_rst) begin
            m_ime = 1'b0; m_eip = 1'b0; m_busy = 1'b0; m_cnt = 0; m_cancel = 1'b0;
            return;
        end
        ime_q.push_back(m_ime);
        act_q.push_back(m_busy);
        wake_q.push_back(s_en && s_halt && (s_irq != 5'd0));
        if (!s_en) return;
        if (m_busy) begin
            m_cnt++;
            a1 = m_sp - 16'd1;
            a2 = m_sp - 16'd2;
            if (s_di) begin m_ime = 1'b0; m_eip = 1'b0; end
            if (m_cnt == 3) begin
                wr_q.push_back({a1, m_pc[15:8]});
`ifdef DISPATCH_CANCEL_EN
                if (s_irq != 5'd0) m_vec = lowest(s_irq);
                else m_cancel = 1'b1;
`endif
            end
            if (m_cnt == 4) wr_q.push_back({a2, m_pc[7:0]});
            if (m_cnt == 5) begin
                vaddr = m_cancel ? 16'h0000 : 16'(16'h0040 + 8 * m_vec);
                jmp_q.push_back({vaddr, a2, ~m_cancel});
                m_busy = 1'b0;
            end
        end else if (m_ime && (s_irq != 5'd0) && (s_bnd || s_halt)) begin
            m_busy = 1'b1; m_cnt = 0; m_cancel = 1'b0;
            m_pc = s_pc; m_sp = s_sp; m_vec = lowest(s_irq);
            m_ime = 1'b0; m_eip = 1'b0;
        end else begin
            logic n_ime, n_eip;
            n_ime = m_ime;
            n_eip = m_eip;
            if (m_eip && s_bnd) begin n_ime = 1'b1; n_eip = 1'b0; end
            if (s_ei) n_eip = 1'b1;
            if (s_reti) begin n_ime = 1'b1; n_eip = 1'b0; end
            if (s_di) begin n_ime = 1'b0; n_eip = 1'b0; end
            m_ime = n_ime;
            m_eip = n_eip;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        rst                  = s_rst;
        bus.i_Enable         = s_en;
        bus.i_Interrupts     = s_irq;
        bus.i_Instr_Boundary = s_bnd;
        bus.i_Halt           = s_halt;
        bus.i_EI             = s_ei;
        bus.i_DI             = s_di;
        bus.i_RETI           = s_reti;
        bus.i_PC             = s_pc;
        bus.i_SP             = s_sp;
        #1;
        model_step();
        s_ei = 1'b0; s_di = 1'b0; s_reti = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // monitor: compares whatever the DUT presents against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                if (ime_q.size() == 0 || act_q.size() == 0 || wake_q.size() == 0) begin
                    chk("model_queue_underflow", 64'd0, 64'd1);
                end else begin
                    chk("ime", bus.o_IME, ime_q.pop_front());
                    chk("dispatch_active", bus.o_Dispatch_Active, act_q.pop_front());
                    chk("wake", bus.o_Wake, wake_q.pop_front());
                end
                if (bus.o_Mem_Wr === 1'b1) begin
                    if (wr_q.size() == 0) chk("unexpected_write", {bus.o_Mem_Addr, bus.o_Mem_Data}, 64'd0);
                    else chk("stack_write", {bus.o_Mem_Addr, bus.o_Mem_Data}, wr_q.pop_front());
                end
                if (bus.o_Load_PC === 1'b1 || bus.o_Load_SP === 1'b1 || bus.o_Interrupt_Handled === 1'b1) begin
                    chk("load_pc_sp_pair", {bus.o_Load_PC, bus.o_Load_SP}, 2'b11);
                    if (jmp_q.size() == 0)
                        chk("unexpected_jump", {bus.o_PC_Out, bus.o_SP_Out, bus.o_Interrupt_Handled}, 64'd0);
                    else
                        chk("jump", {bus.o_PC_Out, bus.o_SP_Out, bus.o_Interrupt_Handled}, jmp_q.pop_front());
                end
                chk("missing_write", 64'(wr_q.size()), 64'd0);
                chk("missing_jump", 64'(jmp_q.size()), 64'd0);
            end
        end
    end

    initial begin
        bus.i_Enable = 1'b0; bus.i_Interrupts = '0; bus.i_Instr_Boundary = 1'b0; bus.i_Halt = 1'b0;
        bus.i_EI = 1'b0; bus.i_DI = 1'b0; bus.i_RETI = 1'b0; bus.i_PC = '0; bus.i_SP = '0;

        s_rst = 1'b1; s_en = 1'b1;
        run(3);
        s_rst = 1'b0;
        tick();
        #2;
        chk("reset_ime", bus.o_IME, 1'b0);
        chk("reset_active", bus.o_Dispatch_Active, 1'b0);
        chk("reset_outputs", {bus.o_Mem_Wr, bus.o_Load_PC, bus.o_Load_SP, bus.o_Interrupt_Handled, bus.o_Wake}, 5'b0);

        // basic dispatch, line 2 -> 0x0050, with a stalled M-cycle in the middle
        s_reti = 1'b1; tick();
        s_irq = 5'b00100; s_bnd = 1'b1; s_pc = 16'h1234; s_sp = 16'hFFFE; tick();
        s_irq = 5'b00100; s_bnd = 1'b0; s_pc = 16'h5555; s_sp = 16'h1111;
        run(2); s_en = 1'b0; run(2); s_en = 1'b1; run(4);
        s_irq = 5'd0; run(1);

        // priority: 10011 -> 0x0040, then 10010 -> 0x0048
        s_reti = 1'b1; tick();
        s_irq = 5'b10011; s_bnd = 1'b1; s_pc = 16'hABCD; s_sp = 16'hC000; tick();
        s_bnd = 1'b0; run(6);
        s_irq = 5'b10010; s_reti = 1'b1; tick();
        s_bnd = 1'b1; tick();
        s_bnd = 1'b0; run(6);
        s_irq = 5'd0; run(1);

        // EI delay: first boundary after EI must not dispatch
        s_ei = 1'b1; tick();
        s_irq = 5'b00001; s_bnd = 1'b1; tick();
        #2; chk("ei_first_boundary_no_dispatch", bus.o_Dispatch_Active, 1'b0);
        s_bnd = 1'b0; tick();
        s_bnd = 1'b1; tick();
        s_bnd = 1'b0; s_irq = 5'd0; run(6);

        // DI beats EI in the same cycle
        s_di = 1'b1; s_ei = 1'b1; tick();
        s_bnd = 1'b1; run(3);
        #2; chk("di_ei_same_cycle_ime", bus.o_IME, 1'b0);
        s_bnd = 1'b0;

        // HALT wake with IME=0
        s_halt = 1'b1; s_irq = 5'b00010; tick();
        s_halt = 1'b0; s_irq = 5'd0; run(2);

        // SP wraps at 0x0000
        s_reti = 1'b1; tick();
        s_sp = 16'h0000; s_pc = 16'h8001; s_irq = 5'b01000; s_bnd = 1'b1; tick();
        s_bnd = 1'b0; run(6);
        s_irq = 5'd0; run(1);

        // reset during PUSH_LO: no low-byte write, no jump
        s_reti = 1'b1; tick();
        s_sp = 16'hD000; s_pc = 16'h4242; s_irq = 5'b00001; s_bnd = 1'b1; tick();
        s_bnd = 1'b0; run(3);
        s_rst = 1'b1; tick();
        s_rst = 1'b0; s_irq = 5'd0; run(3);
        #2; chk("post_abort_ime", bus.o_IME, 1'b0);

`ifdef DISPATCH_CANCEL_EN
        // pending line withdrawn before PUSH_HI is sampled -> PC 0x0000, no handled
        s_reti = 1'b1; tick();
        s_sp = 16'hFFF0; s_pc = 16'h0777; s_irq = 5'b00100; s_bnd = 1'b1; tick();
        s_bnd = 1'b0; run(2);
        s_irq = 5'd0; run(4);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_en   = ($urandom_range(0, 99) < 75);
            s_irq  = ($urandom_range(0, 99) < 40) ? 5'($urandom) : 5'd0;
            s_bnd  = ($urandom_range(0, 99) < 40);
            s_halt = ($urandom_range(0, 99) < 8);
            s_ei   = ($urandom_range(0, 99) < 6);
            s_di   = ($urandom_range(0, 99) < 4);
            s_reti = ($urandom_range(0, 99) < 6);
            s_pc   = 16'($urandom);
            s_sp   = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
            s_rst  = ($urandom_range(0, 199) == 0);
            tick();
        end

        s_rst = 1'b0; s_en = 1'b1; s_irq = 5'd0; s_bnd = 1'b0; s_halt = 1'b0;
        run(8);
        #3;
        chk("leftover_writes", 64'(wr_q.size()), 64'd0);
        chk("leftover_jumps", 64'(jmp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
